// File: rtl/r2a03_bus_sequencer.sv
// r2a03_bus_sequencer: time-multiplexes the R2A03 core bus onto the TinyTapeout pins in 4-phase windows.
// Optional RDY stall support is compiled in by defining BUS_STALL_EN.

module r2a03_bus_sequencer #(
    parameter int          RESET_CYCLES = 8,
    parameter int          SAMPLE_PHASE = 1,
    parameter logic [7:0]  IDLE_CTRL    = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_ctrl,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_cen,
    output logic        cpu_rst,
    input  logic        rdy,
    output logic [7:0]  pin_out,
    input  logic [7:0]  pin_io_in,
    output logic [7:0]  pin_io_out,
    output logic [7:0]  pin_io_oe,
    output logic [1:0]  phase,
    output logic        stalled
);

    localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [1:0] SAMPLE_PH = 2'(SAMPLE_PHASE);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  din_q, din_d;
    logic        miss_q, miss_d;

    logic advance;
    logic stall_req;
    logic is_read;

    assign advance = ena & ~rst;
    assign is_read = ctrl_q[0];

`ifdef BUS_STALL_EN
    // rdy only matters for read windows once the core is out of reset.
    assign stall_req = ~rdy & is_read & (state_q != ST_HOLD);
`else
    logic unused_rdy;
    assign unused_rdy = rdy;
    assign stall_req  = 1'b0;
`endif

    assign cpu_cen = advance & (ph_q == 2'd2) & ~stall_req;
    assign cpu_rst = (state_q == ST_HOLD);
    assign stalled = (state_q == ST_STALL);
    assign phase   = ph_q;
    assign cpu_din = din_q;

    always_comb begin
        pin_out    = ctrl_q;
        pin_io_out = 8'h00;
        pin_io_oe  = 8'h00;
        case (ph_q)
            2'd0:    pin_out = ctrl_q;
            2'd1:    pin_out = addr_q[7:0];
            2'd2:    pin_out = ctrl_q;
            default: pin_out = addr_q[15:8];
        endcase
        // ph0 of a write window leaves the bidir pins released as a turnaround slot.
        if (!is_read) begin
            pin_io_out = dout_q;
            pin_io_oe  = (ph_q == 2'd0) ? 8'h00 : 8'hFF;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        hold_cnt_d = hold_cnt_q;
        addr_d     = addr_q;
        ctrl_d     = ctrl_q;
        dout_d     = dout_q;
        din_d      = din_q;
        miss_d     = miss_q;
        if (advance) begin
            ph_d = ph_q + 2'd1;
            if (ph_q == SAMPLE_PH && is_read) begin
                din_d = pin_io_in;
            end
            // Remember the ph2 stall decision, since rdy may change before the window ends.
            if (ph_q == 2'd2) begin
                miss_d = stall_req;
            end
            if (ph_q == 2'd3) begin
                miss_d = 1'b0;
                case (state_q)
                    ST_HOLD: begin
                        addr_d = cpu_addr;
                        ctrl_d = cpu_ctrl;
                        dout_d = cpu_dout;
                        if (hold_cnt_q != 8'hFF) begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        if (miss_q) begin
                            state_d = ST_STALL;
                        end else begin
                            state_d = ST_RUN;
                            addr_d  = cpu_addr;
                            ctrl_d  = cpu_ctrl;
                            dout_d  = cpu_dout;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            ph_q       <= 2'd0;
            hold_cnt_q <= 8'd0;
            addr_q     <= 16'h0000;
            ctrl_q     <= IDLE_CTRL;
            dout_q     <= 8'h00;
            din_q      <= 8'h00;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            hold_cnt_q <= hold_cnt_d;
            addr_q     <= addr_d;
            ctrl_q     <= ctrl_d;
            dout_q     <= dout_d;
            din_q      <= din_d;
            miss_q     <= miss_d;
        end
    end

endmodule

// File: tb/tb_r2a03_bus_sequencer.sv
// tb_r2a03_bus_sequencer: directed bench for the bus sequencer (reset, hold release, read/write mux, stall, freeze).
// Stall expectations follow BUS_STALL_EN, matching however the design is built.

module tb_r2a03_bus_sequencer;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_ctrl;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_cen;
    logic        cpu_rst;
    logic        rdy;
    logic [7:0]  pin_out;
    logic [7:0]  pin_io_in;
    logic [7:0]  pin_io_out;
    logic [7:0]  pin_io_oe;
    logic [1:0]  phase;
    logic        stalled;

    int checks   = 0;
    int failures = 0;

    r2a03_bus_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .cpu_addr   (cpu_addr),
        .cpu_ctrl   (cpu_ctrl),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_cen    (cpu_cen),
        .cpu_rst    (cpu_rst),
        .rdy        (rdy),
        .pin_out    (pin_out),
        .pin_io_in  (pin_io_in),
        .pin_io_out (pin_io_out),
        .pin_io_oe  (pin_io_oe),
        .phase      (phase),
        .stalled    (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] ctrl, input logic [7:0] dout);
        cpu_addr = addr;
        cpu_ctrl = ctrl;
        cpu_dout = dout;
    endtask

    // Advance one clock and land 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        ena       = 1'b0;
        rdy       = 1'b1;
        pin_io_in = 8'h00;
        applyStimulus(16'h0000, 8'hFF, 8'h00);

        // Reset held for two clocks.
        tick();
        tick();
        checkOutput("rst_phase",   {14'd0, phase},     16'h0000);
        checkOutput("rst_pin_out", {8'd0, pin_out},    16'h00FF);
        checkOutput("rst_cpu_rst", {15'd0, cpu_rst},   16'h0001);
        checkOutput("rst_cpu_din", {8'd0, cpu_din},    16'h0000);
        checkOutput("rst_oe",      {8'd0, pin_io_oe},  16'h0000);
        checkOutput("rst_io_out",  {8'd0, pin_io_out}, 16'h0000);
        checkOutput("rst_stalled", {15'd0, stalled},   16'h0000);
        checkOutput("rst_cen",     {15'd0, cpu_cen},   16'h0000);

        // Release: eight hold windows, cen only at ph2, cpu_rst high throughout.
        rst = 1'b0;
        ena = 1'b1;
        #1;
        for (int k = 0; k < 32; k++) begin
            checkOutput("hold_phase",   {14'd0, phase},   16'(k % 4));
            checkOutput("hold_cen",     {15'd0, cpu_cen}, (k % 4 == 2) ? 16'h0001 : 16'h0000);
            checkOutput("hold_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
            tick();
        end
        checkOutput("run_cpu_rst", {15'd0, cpu_rst}, 16'h0000);
        checkOutput("run_phase",   {14'd0, phase},   16'h0000);

        // Read C0DE/5B issued during this window.
        applyStimulus(16'hC0DE, 8'h5B, 8'h00);
        tick();
        tick();
        checkOutput("rd_setup_cen", {15'd0, cpu_cen}, 16'h0001);
        tick();
        tick();
        checkOutput("rd_ph0_pin", {8'd0, pin_out},   16'h005B);
        checkOutput("rd_ph0_oe",  {8'd0, pin_io_oe}, 16'h0000);
        pin_io_in = 8'hA7;
        tick();
        checkOutput("rd_ph1_pin", {8'd0, pin_out},   16'h00DE);
        checkOutput("rd_ph1_din", {8'd0, cpu_din},   16'h0000);
        checkOutput("rd_ph1_oe",  {8'd0, pin_io_oe}, 16'h0000);
        applyStimulus(16'h1234, 8'h5A, 8'h3C);
        tick();
        checkOutput("rd_ph2_pin", {8'd0, pin_out},   16'h005B);
        checkOutput("rd_ph2_din", {8'd0, cpu_din},   16'h00A7);
        checkOutput("rd_ph2_cen", {15'd0, cpu_cen},  16'h0001);
        tick();
        checkOutput("rd_ph3_pin", {8'd0, pin_out},    16'h00C0);
        checkOutput("rd_ph3_io",  {8'd0, pin_io_out}, 16'h0000);

        // Write window 1234/5A/3C; rdy low must not matter here.
        tick();
        rdy       = 1'b0;
        pin_io_in = 8'h55;
        #1;
        checkOutput("wr_ph0_pin", {8'd0, pin_out},    16'h005A);
        checkOutput("wr_ph0_oe",  {8'd0, pin_io_oe},  16'h0000);
        checkOutput("wr_ph0_io",  {8'd0, pin_io_out}, 16'h003C);
        tick();
        checkOutput("wr_ph1_oe",  {8'd0, pin_io_oe},  16'h00FF);
        checkOutput("wr_ph1_pin", {8'd0, pin_out},    16'h0034);
        tick();
        checkOutput("wr_ph2_oe",  {8'd0, pin_io_oe},  16'h00FF);
        checkOutput("wr_ph2_din", {8'd0, cpu_din},    16'h00A7);
        checkOutput("wr_ph2_cen", {15'd0, cpu_cen},   16'h0001);
        checkOutput("wr_ph2_stl", {15'd0, stalled},   16'h0000);
        tick();
        checkOutput("wr_ph3_oe",  {8'd0, pin_io_oe},  16'h00FF);
        checkOutput("wr_ph3_pin", {8'd0, pin_out},    16'h0012);
        checkOutput("wr_ph3_io",  {8'd0, pin_io_out}, 16'h003C);
        applyStimulus(16'hBEEF, 8'hC3, 8'h00);

        // Read window BEEF/C3 with rdy low.
        tick();
        pin_io_in = 8'h66;
        #1;
        checkOutput("st1_ph0_pin", {8'd0, pin_out},   16'h00C3);
        checkOutput("st1_ph0_stl", {15'd0, stalled},  16'h0000);
        checkOutput("st1_ph0_oe",  {8'd0, pin_io_oe}, 16'h0000);
        tick();
        tick();
        checkOutput("st1_ph2_din", {8'd0, cpu_din},   16'h0066);
`ifdef BUS_STALL_EN
        checkOutput("st1_ph2_cen", {15'd0, cpu_cen},  16'h0000);
`else
        checkOutput("st1_ph2_cen", {15'd0, cpu_cen},  16'h0001);
`endif
        tick();
        applyStimulus(16'h0F0F, 8'h11, 8'h00);

        // Second window with rdy low.
        tick();
        pin_io_in = 8'h77;
        #1;
`ifdef BUS_STALL_EN
        checkOutput("st2_ph0_stl", {15'd0, stalled},  16'h0001);
        checkOutput("st2_ph0_pin", {8'd0, pin_out},   16'h00C3);
`else
        checkOutput("st2_ph0_stl", {15'd0, stalled},  16'h0000);
        checkOutput("st2_ph0_pin", {8'd0, pin_out},   16'h0011);
`endif
        tick();
`ifdef BUS_STALL_EN
        checkOutput("st2_ph1_pin", {8'd0, pin_out},   16'h00EF);
`else
        checkOutput("st2_ph1_pin", {8'd0, pin_out},   16'h000F);
`endif
        tick();
        checkOutput("st2_ph2_din", {8'd0, cpu_din},   16'h0077);
`ifdef BUS_STALL_EN
        checkOutput("st2_ph2_cen", {15'd0, cpu_cen},  16'h0000);
`else
        checkOutput("st2_ph2_cen", {15'd0, cpu_cen},  16'h0001);
`endif
        tick();

        // rdy returns: cen fires at ph2 and the sequencer resumes.
        tick();
        rdy = 1'b1;
        #1;
`ifdef BUS_STALL_EN
        checkOutput("st3_ph0_stl", {15'd0, stalled},  16'h0001);
        checkOutput("st3_ph0_pin", {8'd0, pin_out},   16'h00C3);
`else
        checkOutput("st3_ph0_stl", {15'd0, stalled},  16'h0000);
        checkOutput("st3_ph0_pin", {8'd0, pin_out},   16'h0011);
`endif
        tick();
        tick();
        checkOutput("st3_ph2_cen", {15'd0, cpu_cen},  16'h0001);
        tick();
        tick();
        checkOutput("resume_stl",   {15'd0, stalled}, 16'h0000);
        checkOutput("resume_pin",   {8'd0, pin_out},  16'h0011);
        checkOutput("resume_phase", {14'd0, phase},   16'h0000);

        // Freeze at ph1 for five clocks.
        tick();
        ena = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("frz_phase", {14'd0, phase},   16'h0001);
            checkOutput("frz_pin",   {8'd0, pin_out},  16'h000F);
            checkOutput("frz_cen",   {15'd0, cpu_cen}, 16'h0000);
            tick();
        end
        checkOutput("frz_end_phase", {14'd0, phase}, 16'h0001);
        ena = 1'b1;
        tick();
        checkOutput("thaw_phase", {14'd0, phase},   16'h0002);
        checkOutput("thaw_cen",   {15'd0, cpu_cen}, 16'h0001);

        // Abort at ph2 with reset.
        rst = 1'b1;
        #1;
        checkOutput("abort_cen", {15'd0, cpu_cen}, 16'h0000);
        tick();
        checkOutput("abort_phase",   {14'd0, phase},     16'h0000);
        checkOutput("abort_pin",     {8'd0, pin_out},    16'h00FF);
        checkOutput("abort_cpu_rst", {15'd0, cpu_rst},   16'h0001);
        checkOutput("abort_din",     {8'd0, cpu_din},    16'h0000);
        checkOutput("abort_oe",      {8'd0, pin_io_oe},  16'h0000);
        checkOutput("abort_stl",     {15'd0, stalled},   16'h0000);
        rst = 1'b0;
        tick();
        checkOutput("rerun_phase",   {14'd0, phase},     16'h0001);
        checkOutput("rerun_cpu_rst", {15'd0, cpu_rst},   16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
